// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fcpu_pkg
// Purpose  : Shared widths and the code-RAM loader state encoding for the
//            fcpu core and its boot-loadable code memory.
// Contents : DATA_W, CRAM_ADDR_W defaults; CRAM_BYTES; CRAM_HDR_W;
//            cram_state_t (HDR0 / HDR1 / LOAD / RUN).
// Revision : 1.0 - initial release
// ============================================================================
package fcpu_pkg;

    localparam int DATA_W      = 32;
    localparam int CRAM_ADDR_W = 8;
    localparam int CRAM_BYTES  = DATA_W / 8;
    localparam int CRAM_HDR_W  = 16;

    typedef enum logic [1:0] {
        CRAM_HDR0 = 2'd0,
        CRAM_HDR1 = 2'd1,
        CRAM_LOAD = 2'd2,
        CRAM_RUN  = 2'd3
    } cram_state_t;

endpackage
`default_nettype wire

// File: rtl/fcpu_sram.sv
`default_nettype none
// ============================================================================
// Module   : fcpu_sram
// Purpose  : Simple dual-port RAM, one synchronous write port and one
//            synchronous read port. A read and write to the same address in
//            the same cycle returns the old contents.
// Ports    : clk, nrst (sync, active-low, clears the read register only),
//            we / waddr / wdata (write port), raddr / rdata (read port).
// Revision : 1.0 - initial release
// ============================================================================
module fcpu_sram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    // Contents are never reset, so they survive nrst and reloads.
    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fcpu_cram.sv
`default_nettype none
// ============================================================================
// Module   : fcpu_cram
// Purpose  : fcpu code memory with a byte-stream boot loader. Accepts a
//            16-bit little-endian word count followed by little-endian
//            instruction words, then releases the core and serves fetches
//            with one cycle of read latency.
// Ports    : clk, nrst (sync, active-low)
//            ld_data / ld_valid / ld_ready : loader byte stream
//            reload       : re-enter loading (RUN only)
//            rd_addr / rd_data : instruction fetch port
//            core_nrst    : active-low core reset, high only in RUN
//            loaded_words : words written by the current / last load
//            err          : sticky header overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module fcpu_cram
    import fcpu_pkg::*;
#(
    parameter int DATA_W    = fcpu_pkg::DATA_W,
    parameter int ADDR_W    = fcpu_pkg::CRAM_ADDR_W,
    parameter int BOOT_LOAD = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              core_nrst,
    output logic [ADDR_W:0]   loaded_words,
    output logic              err
);

    localparam int                    c_BYTES     = DATA_W / 8;
    localparam int                    c_BIDX_W    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BIDX_W-1:0]   c_LAST_BIDX = c_BIDX_W'(c_BYTES - 1);
    localparam logic [CRAM_HDR_W:0]   c_DEPTH     = (CRAM_HDR_W + 1)'(1) << ADDR_W;
    localparam cram_state_t           c_RST_STATE = (BOOT_LOAD != 0) ? CRAM_HDR0 : CRAM_RUN;

    cram_state_t           r_state;
    cram_state_t           w_state_nxt;
    logic [7:0]            r_hdr_lo;
    logic [CRAM_HDR_W-1:0] r_n;
    // Word index counts every accepted word, including dropped ones, so it
    // needs the full header width to detect the end of an oversized image.
    logic [CRAM_HDR_W-1:0] r_widx;
    logic [c_BIDX_W-1:0]   r_bidx;
    logic [DATA_W-1:0]     r_partial;
    logic [ADDR_W:0]       r_loaded;
    logic                  r_err;
    logic                  r_core_nrst;

    logic                  w_ld_ready;
    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_in_range;
    logic                  w_final_word;
    logic                  w_we;
    logic [CRAM_HDR_W-1:0] w_hdr_n;
    logic [DATA_W-1:0]     w_wdata;

    assign w_accept     = ld_valid && w_ld_ready;
    assign w_hdr_n      = {ld_data, r_hdr_lo};
    assign w_last_byte  = (r_bidx == c_LAST_BIDX);
    assign w_in_range   = ((CRAM_HDR_W + 1)'(r_widx) < c_DEPTH);
    assign w_final_word = (((CRAM_HDR_W + 1)'(r_widx) + (CRAM_HDR_W + 1)'(1))
                           == (CRAM_HDR_W + 1)'(r_n));

    // The last byte goes straight into the RAM write word, not via r_partial.
    always_comb begin
        w_wdata                  = r_partial;
        w_wdata[DATA_W-1 -: 8]   = ld_data;
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CRAM_HDR0: if (w_accept) w_state_nxt = CRAM_HDR1;
            CRAM_HDR1: if (w_accept) w_state_nxt = (w_hdr_n == '0) ? CRAM_RUN : CRAM_LOAD;
            CRAM_LOAD: if (w_accept && w_last_byte && w_final_word) w_state_nxt = CRAM_RUN;
            CRAM_RUN:  if (reload) w_state_nxt = CRAM_HDR0;
            default:   w_state_nxt = c_RST_STATE;
        endcase
    end

    // Gated by nrst so the stream sees "not ready" while reset is held.
    always_comb begin
        w_ld_ready = nrst && (r_state != CRAM_RUN);
        w_we       = (r_state == CRAM_LOAD) && w_accept && w_last_byte && w_in_range;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_hdr_lo  <= '0;
            r_n       <= '0;
            r_widx    <= '0;
            r_bidx    <= '0;
            r_partial <= '0;
            r_loaded  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                CRAM_HDR0: begin
                    if (w_accept) r_hdr_lo <= ld_data;
                end
                CRAM_HDR1: begin
                    if (w_accept) begin
                        r_n      <= w_hdr_n;
                        r_widx   <= '0;
                        r_bidx   <= '0;
                        r_loaded <= '0;
                        if ((CRAM_HDR_W + 1)'(w_hdr_n) > c_DEPTH) r_err <= 1'b1;
                    end
                end
                CRAM_LOAD: begin
                    if (w_accept) begin
                        r_partial[{r_bidx, 3'b000} +: 8] <= ld_data;
                        if (w_last_byte) begin
                            r_bidx <= '0;
                            r_widx <= r_widx + CRAM_HDR_W'(1);
                            if (w_in_range) r_loaded <= r_loaded + (ADDR_W + 1)'(1);
                        end else begin
                            r_bidx <= r_bidx + c_BIDX_W'(1);
                        end
                    end
                end
                CRAM_RUN: begin
                    if (reload) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Registered so the core sees a clean, glitch-free reset release.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_core_nrst <= 1'b0;
        end else begin
            r_core_nrst <= (r_state == CRAM_RUN);
        end
    end

    fcpu_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .nrst  (nrst),
        .we    (w_we),
        .waddr (r_widx[ADDR_W-1:0]),
        .wdata (w_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign ld_ready     = w_ld_ready;
    assign core_nrst    = r_core_nrst;
    assign loaded_words = r_loaded;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fcpu_cram.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcpu_cram
// Purpose  : Directed self-checking bench for fcpu_cram. Instance A uses a
//            16-word RAM with boot loading; instance B uses a 4-word RAM
//            that starts directly in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fcpu_cram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ADDR_W = 4, BOOT_LOAD = 1
    logic        a_nrst, a_ld_valid, a_ld_ready, a_reload, a_core_nrst, a_err;
    logic [7:0]  a_ld_data;
    logic [3:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [4:0]  a_loaded_words;

    // Instance B: ADDR_W = 2, BOOT_LOAD = 0
    logic        b_nrst, b_ld_valid, b_ld_ready, b_reload, b_core_nrst, b_err;
    logic [7:0]  b_ld_data;
    logic [1:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic [2:0]  b_loaded_words;

    int n_cmp = 0;
    int n_err = 0;

    fcpu_cram #(.DATA_W(32), .ADDR_W(4), .BOOT_LOAD(1)) u_dut_a (
        .clk(clk), .nrst(a_nrst), .ld_data(a_ld_data), .ld_valid(a_ld_valid),
        .ld_ready(a_ld_ready), .reload(a_reload), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .core_nrst(a_core_nrst),
        .loaded_words(a_loaded_words), .err(a_err)
    );

    fcpu_cram #(.DATA_W(32), .ADDR_W(2), .BOOT_LOAD(0)) u_dut_b (
        .clk(clk), .nrst(b_nrst), .ld_data(b_ld_data), .ld_valid(b_ld_valid),
        .ld_ready(b_ld_ready), .reload(b_reload), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .core_nrst(b_core_nrst),
        .loaded_words(b_loaded_words), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] b);
        a_ld_data  = b;
        a_ld_valid = 1'b1;
        tick();
        a_ld_valid = 1'b0;
    endtask

    task automatic a_send_gap(input logic [7:0] b);
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            a_ld_valid = 1'b0;
            a_ld_data  = 8'($urandom);
            tick();
        end
        a_send(b);
    endtask

    task automatic a_word(input logic [31:0] w, input bit gapped);
        for (int k = 0; k < 4; k++) begin
            if (gapped) a_send_gap(w[8*k +: 8]);
            else        a_send(w[8*k +: 8]);
        end
    endtask

    task automatic a_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        a_rd_addr = addr;
        tick();
        check(tag, a_rd_data, exp);
    endtask

    task automatic a_pulse_reload();
        a_reload = 1'b1;
        tick();
        a_reload = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] b);
        b_ld_data  = b;
        b_ld_valid = 1'b1;
        tick();
        b_ld_valid = 1'b0;
    endtask

    task automatic b_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) b_send(w[8*k +: 8]);
    endtask

    task automatic b_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        b_rd_addr = addr;
        tick();
        check(tag, b_rd_data, exp);
    endtask

    initial begin
        logic [31:0] w4;
        a_nrst = 1'b0; a_ld_valid = 1'b0; a_ld_data = '0; a_reload = 1'b0; a_rd_addr = '0;
        b_nrst = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0; b_reload = 1'b0; b_rd_addr = '0;
        tick();
        tick();

        // ---- reset state
        check("rst_ld_ready",  32'(a_ld_ready), 32'd0);
        check("rst_core_nrst", 32'(a_core_nrst), 32'd0);
        check("rst_loaded",    32'(a_loaded_words), 32'd0);
        check("rst_err",       32'(a_err), 32'd0);
        check("rst_rd_data",   a_rd_data, 32'd0);
        a_nrst = 1'b1;
        tick();
        check("hdr0_ld_ready", 32'(a_ld_ready), 32'd1);

        // ---- basic load: 02 00 78 56 34 12 EF BE AD DE
        a_send(8'h02);
        a_send(8'h00);
        a_word(32'h12345678, 1'b0);
        check("basic_core_nrst_low", 32'(a_core_nrst), 32'd0);
        a_word(32'hDEADBEEF, 1'b0);
        // A byte offered right after the final byte must be refused.
        a_ld_data  = 8'h55;
        a_ld_valid = 1'b1;
        #1;
        check("basic_ready_fall",   32'(a_ld_ready), 32'd0);
        check("basic_core_nrst_0",  32'(a_core_nrst), 32'd0);
        check("basic_loaded",       32'(a_loaded_words), 32'd2);
        check("basic_err",          32'(a_err), 32'd0);
        tick();
        a_ld_valid = 1'b0;
        check("basic_core_nrst_1",  32'(a_core_nrst), 32'd1);
        check("basic_no_extra",     32'(a_loaded_words), 32'd2);
        a_read("basic_mem0", 4'd0, 32'h12345678);
        a_read("basic_mem1", 4'd1, 32'hDEADBEEF);

        // ---- gapped valid: N = 3
        a_pulse_reload();
        check("gap_ready_hdr",      32'(a_ld_ready), 32'd1);
        check("gap_err",            32'(a_err), 32'd0);
        a_send_gap(8'h03);
        check("gap_core_nrst_low",  32'(a_core_nrst), 32'd0);
        a_send_gap(8'h00);
        a_word(32'h11223344, 1'b1);
        a_word(32'h55667788, 1'b1);
        a_word(32'h99AABBCC, 1'b1);
        check("gap_loaded",         32'(a_loaded_words), 32'd3);
        check("gap_ready_run",      32'(a_ld_ready), 32'd0);
        a_read("gap_mem0", 4'd0, 32'h11223344);
        a_read("gap_mem1", 4'd1, 32'h55667788);
        a_read("gap_mem2", 4'd2, 32'h99AABBCC);

        // ---- empty image
        a_pulse_reload();
        a_send(8'h00);
        a_send(8'h00);
        check("empty_ready",        32'(a_ld_ready), 32'd0);
        check("empty_loaded",       32'(a_loaded_words), 32'd0);
        a_read("empty_mem0", 4'd0, 32'h11223344);
        check("empty_core_nrst",    32'(a_core_nrst), 32'd1);
        a_read("empty_mem2", 4'd2, 32'h99AABBCC);

        // ---- reset in the middle of a word, then a fresh load
        a_pulse_reload();
        a_send(8'h01);
        a_send(8'h00);
        a_send(8'hAA);
        a_send(8'hBB);
        a_nrst = 1'b0;
        tick();
        check("midrst_core_nrst",   32'(a_core_nrst), 32'd0);
        check("midrst_ready",       32'(a_ld_ready), 32'd0);
        a_nrst = 1'b1;
        a_send(8'h01);
        a_send(8'h00);
        a_word(32'h0D0C0B0A, 1'b0);
        check("midrst_loaded",      32'(a_loaded_words), 32'd1);
        a_read("midrst_mem0", 4'd0, 32'h0D0C0B0A);
        a_read("midrst_mem1", 4'd1, 32'h55667788);

        // ---- instance B: BOOT_LOAD = 0 goes straight to RUN
        b_nrst = 1'b1;
        check("b0_core_nrst_c1",    32'(b_core_nrst), 32'd0);
        tick();
        check("b0_core_nrst_c2",    32'(b_core_nrst), 32'd1);
        check("b0_ready",           32'(b_ld_ready), 32'd0);

        // ---- overflow: DEPTH = 4, N = 5
        b_reload = 1'b1;
        tick();
        b_reload = 1'b0;
        check("ovf_ready_hdr",      32'(b_ld_ready), 32'd1);
        b_send(8'h05);
        b_send(8'h00);
        check("ovf_err_set",        32'(b_err), 32'd1);
        for (int i = 0; i < 4; i++) b_word(32'hA0A0A000 + 32'(i));
        w4 = 32'hA0A0A004;
        for (int k = 0; k < 3; k++) b_send(w4[8*k +: 8]);
        check("ovf_ready_19",       32'(b_ld_ready), 32'd1);
        b_send(w4[31:24]);
        check("ovf_ready_20",       32'(b_ld_ready), 32'd0);
        check("ovf_loaded",         32'(b_loaded_words), 32'd4);
        check("ovf_err",            32'(b_err), 32'd1);
        b_read("ovf_mem0", 2'd0, 32'hA0A0A000);
        b_read("ovf_mem1", 2'd1, 32'hA0A0A001);
        b_read("ovf_mem2", 2'd2, 32'hA0A0A002);
        b_read("ovf_mem3", 2'd3, 32'hA0A0A003);

        // ---- reload with one word, reading address 0 throughout
        b_rd_addr = 2'd0;
        b_reload  = 1'b1;
        tick();
        b_reload  = 1'b0;
        check("rl_err_clear",       32'(b_err), 32'd0);
        b_send(8'h01);
        b_send(8'h00);
        check("rl_core_nrst_low",   32'(b_core_nrst), 32'd0);
        b_word(32'hCAFEF00D);
        check("rl_rdw_old",         b_rd_data, 32'hA0A0A000);
        check("rl_loaded",          32'(b_loaded_words), 32'd1);
        tick();
        check("rl_rd_new",          b_rd_data, 32'hCAFEF00D);
        check("rl_core_nrst_high",  32'(b_core_nrst), 32'd1);
        b_read("rl_mem1", 2'd1, 32'hA0A0A001);
        b_read("rl_mem3", 2'd3, 32'hA0A0A003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
